// File: rtl/nonogram_pkg.sv
// Shared types and width helpers for the nonogram line-elimination sequencer.
package nonogram_pkg;

    localparam int unsigned SIZE_DEF     = 4;
    localparam int unsigned MAX_OPTS_DEF = 16;

    // Line index width.
    function automatic int unsigned f_iw(input int unsigned size);
        return $clog2(size);
    endfunction

    // Option count width; must hold MAX_OPTS itself.
    function automatic int unsigned f_cw(input int unsigned max_opts);
        return $clog2(max_opts + 1);
    endfunction

    // Option memory address width: {row, ind, k}.
    function automatic int unsigned f_aw(input int unsigned size, input int unsigned max_opts);
        return 1 + f_iw(size) + $clog2(max_opts);
    endfunction

    localparam int unsigned IW_DEF = f_iw(SIZE_DEF);
    localparam int unsigned CW_DEF = f_cw(MAX_OPTS_DEF);

    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StFetch,
        StIssue,
        StJudge,
        StClose,
        StNext,
        StHalt
    } state_e;

    // Pending-line queue entry; sized from the package defaults.
    typedef struct packed {
        logic              row;
        logic [IW_DEF-1:0] ind;
        logic [CW_DEF-1:0] count;
    } q_entry_t;

endpackage

// File: rtl/line_queue.sv
// Circular FIFO of pending lines; pointers carry one extra wrap bit.
module line_queue #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [Width-1:0]       i_data,
    input  logic                   i_pop,
    output logic [Width-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(Depth):0] o_count
);
    localparam int unsigned PW = $clog2(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [PW:0]      r_wr_ptr;
    logic [PW:0]      r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                       (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_data    = r_mem[r_rd_ptr[PW-1:0]];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Pointer advance; a refused push or pop leaves the pointer alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
    end

endmodule

// File: rtl/line_scheduler.sv
// Walks queued lines through their option lists, compacting survivors in place.
module line_scheduler import nonogram_pkg::*; #(
    parameter int unsigned SIZE     = SIZE_DEF,
    parameter int unsigned MAX_OPTS = MAX_OPTS_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic                          load_row,
    input  logic [f_iw(SIZE)-1:0]         load_ind,
    input  logic [f_cw(MAX_OPTS)-1:0]     load_count,
    input  logic                          start,
    output logic [f_aw(SIZE,MAX_OPTS)-1:0] mem_rd_addr,
    input  logic [SIZE-1:0]               mem_rd_data,
    output logic                          mem_we,
    output logic [f_aw(SIZE,MAX_OPTS)-1:0] mem_wr_addr,
    output logic [SIZE-1:0]               mem_wr_data,
    output logic                          op_valid,
    output logic                          op_row,
    output logic [f_iw(SIZE)-1:0]         op_ind,
    output logic [SIZE-1:0]               op_option,
    input  logic                          chk_contradict,
    output logic                          commit_valid,
    output logic                          commit_row,
    output logic [f_iw(SIZE)-1:0]         commit_ind,
    output logic [SIZE-1:0]               commit_option,
    output logic                          busy,
    output logic                          done,
    output logic                          stuck,
    output logic                          error
);
    localparam int unsigned IW     = f_iw(SIZE);
    localparam int unsigned CW     = f_cw(MAX_OPTS);
    localparam int unsigned KW     = $clog2(MAX_OPTS);
    localparam int unsigned QDEPTH = 2 * SIZE;
    localparam int unsigned OCW    = $clog2(QDEPTH) + 1;

    state_e          r_state;
    logic            r_row;
    logic [IW-1:0]   r_ind;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_k;
    logic [CW-1:0]   r_w;
    logic [SIZE-1:0] r_opt;
    logic [SIZE-1:0] r_surv;
    logic            r_progress;
    logic [OCW-1:0]  r_stall;
    logic            r_done;
    logic            r_stuck;
    logic            r_error;

    q_entry_t        w_q_head;
    q_entry_t        w_push_data;
    logic            w_q_full;
    logic            w_q_empty;
    logic [OCW-1:0]  w_q_count;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_k_inc;
    logic [OCW-1:0]  w_stall_next;

    assign w_k_inc      = r_k + CW'(1);
    assign w_stall_next = r_progress ? '0 : r_stall + OCW'(1);
    assign w_pop        = (r_state == StPop);
    assign w_push       = ((r_state == StIdle) && load_valid && !w_q_full) ||
                          ((r_state == StClose) && (r_w > CW'(1)));

    // Loads enter from the port in IDLE; requeues carry the compacted count.
    always_comb begin
        w_push_data = '{row: r_row, ind: r_ind, count: r_w};
        if (r_state == StIdle) begin
            w_push_data = '{row: load_row, ind: load_ind, count: load_count};
        end
    end

    line_queue #(
        .Width ($bits(q_entry_t)),
        .Depth (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_q_head),
        .o_full  (w_q_full),
        .o_empty (w_q_empty),
        .o_count (w_q_count)
    );

    // Outputs decode from registered state so reset clears them at once.
    assign load_ready    = (r_state == StIdle) && !w_q_full;
    assign mem_rd_addr   = (r_state == StFetch) ? {r_row, r_ind, r_k[KW-1:0]} : '0;
    assign op_valid      = (r_state == StIssue);
    assign op_row        = op_valid ? r_row : 1'b0;
    assign op_ind        = op_valid ? r_ind : '0;
    assign op_option     = op_valid ? mem_rd_data : '0;
    assign mem_we        = (r_state == StJudge) && !chk_contradict;
    assign mem_wr_addr   = mem_we ? {r_row, r_ind, r_w[KW-1:0]} : '0;
    assign mem_wr_data   = mem_we ? r_opt : '0;
    assign commit_valid  = (r_state == StClose) && (r_w == CW'(1));
    assign commit_row    = commit_valid ? r_row : 1'b0;
    assign commit_ind    = commit_valid ? r_ind : '0;
    assign commit_option = commit_valid ? r_surv : '0;
    assign busy          = (r_state != StIdle) && (r_state != StHalt);
    assign done          = r_done;
    assign stuck         = r_stuck;
    assign error         = r_error;

    // Sequencer: one option per FETCH/ISSUE/JUDGE triple, then close out the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_row      <= 1'b0;
            r_ind      <= '0;
            r_count    <= '0;
            r_k        <= '0;
            r_w        <= '0;
            r_opt      <= '0;
            r_surv     <= '0;
            r_progress <= 1'b0;
            r_stall    <= '0;
            r_done     <= 1'b0;
            r_stuck    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        if (w_q_empty) begin
                            r_done  <= 1'b1;
                            r_state <= StHalt;
                        end else begin
                            r_state <= StPop;
                        end
                    end
                end
                StPop: begin
                    r_row   <= w_q_head.row;
                    r_ind   <= w_q_head.ind;
                    r_count <= w_q_head.count;
                    r_k     <= '0;
                    r_w     <= '0;
                    // A zero-count line has nothing to fetch and fails at CLOSE.
                    r_state <= (w_q_head.count == '0) ? StClose : StFetch;
                end
                StFetch: r_state <= StIssue;
                StIssue: begin
                    r_opt   <= mem_rd_data;
                    r_state <= StJudge;
                end
                StJudge: begin
                    if (!chk_contradict) begin
                        r_w <= r_w + CW'(1);
                        if (r_w == '0) r_surv <= r_opt;
                    end
                    r_k     <= w_k_inc;
                    r_state <= (w_k_inc == r_count) ? StClose : StFetch;
                end
                StClose: begin
                    r_progress <= (r_w < r_count) || (r_w == CW'(1));
                    if (r_w == '0) begin
                        r_error <= 1'b1;
                        r_state <= StHalt;
                    end else begin
                        r_state <= StNext;
                    end
                end
                StNext: begin
                    r_stall <= w_stall_next;
                    if (w_q_empty) begin
                        r_done  <= 1'b1;
                        r_state <= StHalt;
                    end else if (w_stall_next == w_q_count) begin
                        r_stuck <= 1'b1;
                        r_state <= StHalt;
                    end else begin
                        r_state <= StPop;
                    end
                end
                StHalt: r_state <= StHalt;
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_line_scheduler.sv
// Bench for line_scheduler: option memory, contradiction oracle and a queue-level model.
module tb_line_scheduler;
    localparam int unsigned SIZE = 4, MAX_OPTS = 16, IW = 2, CW = 5, AW = 7;
    localparam int unsigned BUDGET = 4000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            load_valid = 1'b0, load_row = 1'b0, start = 1'b0;
    logic [IW-1:0]   load_ind = '0;
    logic [CW-1:0]   load_count = '0;
    logic            load_ready;
    logic [AW-1:0]   mem_rd_addr, mem_wr_addr;
    logic [SIZE-1:0] mem_rd_data = '0, mem_wr_data;
    logic            mem_we, op_valid, op_row, commit_valid, commit_row;
    logic [IW-1:0]   op_ind, commit_ind;
    logic [SIZE-1:0] op_option, commit_option;
    logic            chk_contradict = 1'b0;
    logic            busy, done, stuck, error;

    always #5 clk = ~clk;

    line_scheduler #(.SIZE(SIZE), .MAX_OPTS(MAX_OPTS)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_row(load_row), .load_ind(load_ind), .load_count(load_count), .start(start),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .mem_we(mem_we),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .op_valid(op_valid),
        .op_row(op_row), .op_ind(op_ind), .op_option(op_option),
        .chk_contradict(chk_contradict), .commit_valid(commit_valid),
        .commit_row(commit_row), .commit_ind(commit_ind), .commit_option(commit_option),
        .busy(busy), .done(done), .stuck(stuck), .error(error)
    );

    // Option memory (one-cycle read latency) and the contradiction oracle.
    logic [SIZE-1:0] tb_mem [128];
    logic [SIZE-1:0] init_mem [128];
    logic            mem_init = 1'b0;
    bit              bad [8][16];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) tb_mem[i] <= init_mem[i];
        end else if (mem_we) begin
            tb_mem[mem_wr_addr] <= mem_wr_data;
        end
        mem_rd_data <= tb_mem[mem_rd_addr];
        chk_contradict <= op_valid && bad[{op_row, op_ind}][op_option];
    end

    // Observation counters.
    int         n_op, n_we, n_busy, n_pulse_err;
    logic [6:0] obs_commit [$];
    logic       mon_clr = 1'b1;
    logic       prev_op, prev_we, prev_cm;

    always @(negedge clk) begin
        if (mon_clr) begin
            n_op = 0; n_we = 0; n_busy = 0; n_pulse_err = 0;
            obs_commit.delete();
            prev_op = 1'b0; prev_we = 1'b0; prev_cm = 1'b0;
        end else begin
            if (op_valid) n_op++;
            if (mem_we) n_we++;
            if (busy) n_busy++;
            if (commit_valid) obs_commit.push_back({commit_row, commit_ind, commit_option});
            if ((op_valid && prev_op) || (mem_we && prev_we) || (commit_valid && prev_cm))
                n_pulse_err++;
            prev_op = op_valid; prev_we = mem_we; prev_cm = commit_valid;
        end
    end

    int n_assert = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scenario description and model results.
    int         ln_n;
    int         ln_id [8];
    int         ln_cnt [8];
    logic [3:0] mm [128];
    logic [6:0] exp_commit [$];
    int         exp_ops, exp_we, exp_busy;
    bit         exp_done, exp_stuck, exp_err;

    task automatic do_reset();
        rst = 1'b1; mon_clr = 1'b1; load_valid = 1'b0; start = 1'b0;
        mem_init = 1'b1;
        tick();
        mem_init = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic do_load(input string tag, input int id, input int cnt, input logic exp_rdy);
        logic [2:0] idb;
        idb = id[2:0];
        load_valid = 1'b1; load_row = idb[2]; load_ind = idb[1:0]; load_count = cnt[CW-1:0];
        check(tag, load_ready, exp_rdy);
        tick();
        load_valid = 1'b0;
    endtask

    // Queue-level model: pop, filter by oracle, retire/requeue, track stalls.
    task automatic model_run();
        int q [$];
        int cnt [8];
        int stall, w, id;
        logic [2:0] idb;
        logic [3:0] opt;
        bit prog;
        for (int i = 0; i < 128; i++) mm[i] = init_mem[i];
        exp_commit.delete();
        exp_ops = 0; exp_we = 0; exp_busy = 0;
        exp_done = 0; exp_stuck = 0; exp_err = 0;
        for (int i = 0; i < ln_n; i++) begin
            q.push_back(ln_id[i]);
            cnt[ln_id[i]] = ln_cnt[i];
        end
        stall = 0;
        if (q.size() == 0) exp_done = 1;
        while (q.size() != 0) begin
            id = q.pop_front();
            w = 0;
            for (int k = 0; k < cnt[id]; k++) begin
                opt = mm[id * 16 + k];
                exp_ops++;
                if (!bad[id][opt]) begin
                    mm[id * 16 + w] = opt;
                    w++;
                    exp_we++;
                end
            end
            exp_busy += 3 + 3 * cnt[id];
            if (w == 0) begin
                exp_err = 1;
                exp_busy--;
                break;
            end
            prog = (w < cnt[id]) || (w == 1);
            idb = id[2:0];
            if (w == 1) exp_commit.push_back({idb, mm[id * 16]});
            else begin
                q.push_back(id);
                cnt[id] = w;
            end
            stall = prog ? 0 : stall + 1;
            if (q.size() == 0) begin
                exp_done = 1;
                break;
            end
            if (stall == q.size()) begin
                exp_stuck = 1;
                break;
            end
        end
    endtask

    task automatic start_and_compare(input string tag);
        int c;
        int mism;
        model_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (busy && c < BUDGET) begin
            tick();
            c++;
        end
        check({tag, "/halt"}, busy, 1'b0);
        check({tag, "/done"}, done, exp_done);
        check({tag, "/stuck"}, stuck, exp_stuck);
        check({tag, "/error"}, error, exp_err);
        check({tag, "/ops"}, n_op, exp_ops);
        check({tag, "/writes"}, n_we, exp_we);
        check({tag, "/cycles"}, n_busy, exp_busy);
        check({tag, "/pulses"}, n_pulse_err, 0);
        check({tag, "/ncommit"}, obs_commit.size(), exp_commit.size());
        for (int i = 0; i < exp_commit.size() && i < obs_commit.size(); i++)
            check({tag, "/commit"}, obs_commit[i], exp_commit[i]);
        mism = 0;
        for (int i = 0; i < 128; i++) if (tb_mem[i] !== mm[i]) mism++;
        check({tag, "/mem"}, mism, 0);
    endtask

    task automatic clear_tables();
        for (int i = 0; i < 128; i++) init_mem[i] = 4'($urandom);
        for (int i = 0; i < 8; i++) for (int j = 0; j < 16; j++) bad[i][j] = 1'b0;
    endtask

    initial begin
        logic [38:0] outs;
        int perm [8];
        int t, rate, c;

        // Reset state.
        clear_tables();
        do_reset();
        outs = {mem_rd_addr, mem_we, mem_wr_addr, mem_wr_data, op_valid, op_row, op_ind,
                op_option, commit_valid, commit_row, commit_ind, commit_option,
                busy, done, stuck, error};
        check("reset/outs", outs, '0);
        check("reset/load_ready", load_ready, 1'b1);

        // Single row, one option: immediate commit then done.
        clear_tables();
        do_reset();
        ln_n = 1; ln_id[0] = 4; ln_cnt[0] = 1;
        do_load("s1/ready", 4, 1, 1'b1);
        start_and_compare("s1");
        check("s1/op_count", n_op, 1);

        // Compaction: 1010 0110 1001 with the middle one contradicting.
        clear_tables();
        init_mem[80] = 4'b1010; init_mem[81] = 4'b0110; init_mem[82] = 4'b1001;
        bad[5][6] = 1'b1;
        do_reset();
        ln_n = 1; ln_id[0] = 5; ln_cnt[0] = 3;
        do_load("s2/ready", 5, 3, 1'b1);
        start_and_compare("s2");
        check("s2/slot0", tb_mem[80], 4'b1010);
        check("s2/slot1", tb_mem[81], 4'b1001);

        // Two lines, no contradictions: stuck after second NEXT.
        clear_tables();
        do_reset();
        ln_n = 2; ln_id[0] = 0; ln_cnt[0] = 2; ln_id[1] = 1; ln_cnt[1] = 2;
        do_load("s3/ready", 0, 2, 1'b1);
        do_load("s3/ready", 1, 2, 1'b1);
        start_and_compare("s3");
        check("s3/cycles_abs", n_busy, 18);

        // Every option contradicts: error, no commit.
        clear_tables();
        for (int j = 0; j < 16; j++) bad[2][j] = 1'b1;
        do_reset();
        ln_n = 1; ln_id[0] = 2; ln_cnt[0] = 2;
        do_load("s4/ready", 2, 2, 1'b1);
        start_and_compare("s4");
        check("s4/err_abs", error, 1'b1);

        // Fill all eight slots, ninth refused, then run through wrap-around.
        clear_tables();
        for (int i = 0; i < 8; i++) for (int j = 0; j < 16; j++)
            bad[i][j] = ($urandom_range(0, 99) < 40);
        do_reset();
        ln_n = 8;
        for (int i = 0; i < 8; i++) begin
            ln_id[i] = 7 - i;
            ln_cnt[i] = $urandom_range(2, 4);
            do_load("s5/ready", ln_id[i], ln_cnt[i], 1'b1);
        end
        check("s5/full", load_ready, 1'b0);
        do_load("s5/refused", 0, 5, 1'b0);
        start_and_compare("s5");

        // Asynchronous reset during JUDGE.
        clear_tables();
        do_reset();
        do_load("s6/ready", 3, 4, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (!op_valid && c < 20) begin
            tick();
            c++;
        end
        check("s6/op_seen", op_valid, 1'b1);
        tick();
        check("s6/in_judge", mem_we, 1'b1);
        #1 rst = 1'b1;
        #1;
        outs = {mem_rd_addr, mem_we, mem_wr_addr, mem_wr_data, op_valid, op_row, op_ind,
                op_option, commit_valid, commit_row, commit_ind, commit_option,
                busy, done, stuck, error};
        check("s6/outs", outs, '0);
        check("s6/load_ready", load_ready, 1'b1);
        tick();
        rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("s6/empty_done", done, 1'b1);
        check("s6/empty_busy", busy, 1'b0);

        // Randomized scenarios.
        for (int s = 0; s < 10; s++) begin
            clear_tables();
            rate = $urandom_range(15, 85);
            for (int i = 0; i < 8; i++) for (int j = 0; j < 16; j++)
                bad[i][j] = ($urandom_range(0, 99) < rate);
            for (int i = 0; i < 8; i++) perm[i] = i;
            for (int i = 7; i > 0; i--) begin
                int j;
                j = $urandom_range(0, i);
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            do_reset();
            ln_n = $urandom_range(1, 8);
            for (int i = 0; i < ln_n; i++) begin
                ln_id[i] = perm[i];
                ln_cnt[i] = $urandom_range(1, (s < 5) ? 6 : MAX_OPTS);
                do_load("rnd/ready", ln_id[i], ln_cnt[i], 1'b1);
            end
            start_and_compare("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
